// File: rtl/game_pkg.sv
// Shared definitions for the scripted game player: game state codes,
// outcome encoding and the player FSM states.
package game_pkg;

    localparam logic [4:0] S_DEC1     = 5'd1;
    localparam logic [4:0] S_DEC2     = 5'd2;
    localparam logic [4:0] S_DEC6     = 5'd6;
    localparam logic [4:0] S_END9     = 5'd9;
    localparam logic [4:0] S_END10    = 5'd10;
    localparam logic [4:0] S_DEC11    = 5'd11;
    localparam logic [4:0] S_DEC12    = 5'd12;
    localparam logic [4:0] S_END13    = 5'd13;
    localparam logic [4:0] S_INVALID  = 5'd16;
    localparam logic [4:0] S_TERMINAL = 5'd21;

    localparam logic [1:0] OUT_NONE  = 2'd0;
    localparam logic [1:0] OUT_END9  = 2'd1;
    localparam logic [1:0] OUT_END10 = 2'd2;
    localparam logic [1:0] OUT_END13 = 2'd3;

    typedef enum logic [2:0] {
        P_IDLE,
        P_RST1,
        P_RST2,
        P_PLAY,
        P_FINISH,
        P_FAIL
    } player_state_t;

    function automatic logic is_decision(input logic [4:0] code);
        return (code == S_DEC1) || (code == S_DEC2) || (code == S_DEC6) ||
               (code == S_DEC11) || (code == S_DEC12);
    endfunction

endpackage

// File: rtl/decision_fifo.sv
// Script FIFO: DEPTH x 2-bit entries with a show-ahead head output.
// Pushes when full and pops when empty are ignored.
module decision_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [1:0] push_data,
    input  logic       pop,
    output logic [1:0] head,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/game_player.sv
// Plays a preloaded decision script into a game FSM: resets the game, feeds
// decisions at decision states and reports outcome, counts and errors.
module game_player
    import game_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    input  logic [1:0] load_decision,
    output logic       load_ready,
    input  logic       start,
    input  logic [4:0] state,
    output logic       game_rst,
    output logic [1:0] Decision,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] outcome,
    output logic [7:0] move_count,
    output logic [3:0] invalid_count
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] STALL_LAST = TW'(TIMEOUT - 1);

    player_state_t cur, nxt;
    logic [TW-1:0] stall;
    logic          pop;
    logic          push;
    logic          dec;
    logic [1:0]    head;
    logic          full;
    logic          empty;

    assign dec        = is_decision(state);
    assign load_ready = !full && !busy;
    assign push       = load_valid && load_ready;

    decision_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (load_decision),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= P_IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt      = cur;
        pop      = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        game_rst = 1'b0;
        Decision = 2'd0;
        case (cur)
            // FINISH and FAIL behave exactly like IDLE when start arrives.
            P_IDLE, P_FINISH, P_FAIL: begin
                done  = (cur == P_FINISH);
                error = (cur == P_FAIL);
                if (start) nxt = empty ? P_FAIL : P_RST1;
            end
            P_RST1: begin
                busy     = 1'b1;
                game_rst = 1'b1;
                nxt      = P_RST2;
            end
            P_RST2: begin
                busy     = 1'b1;
                game_rst = 1'b1;
                nxt      = P_PLAY;
            end
            P_PLAY: begin
                busy     = 1'b1;
                Decision = head;
                if (state > S_TERMINAL) begin
                    nxt = P_FAIL;
                end else if (state == S_TERMINAL) begin
                    nxt = P_FINISH;
                end else if (dec) begin
                    if (empty) nxt = P_FAIL;
                    else       pop = 1'b1;
                end else if (stall == STALL_LAST) begin
                    nxt = P_FAIL;
                end
            end
            default: nxt = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall         <= '0;
            move_count    <= '0;
            invalid_count <= '0;
            outcome       <= OUT_NONE;
        end else begin
            if (cur == P_PLAY && !dec) stall <= stall + 1'b1;
            else                       stall <= '0;

            if (nxt == P_RST1) begin
                move_count    <= '0;
                invalid_count <= '0;
                outcome       <= OUT_NONE;
            end else if (cur == P_PLAY) begin
                if (pop && move_count != 8'hFF) move_count <= move_count + 1'b1;
                if (state == S_INVALID && invalid_count != 4'hF)
                    invalid_count <= invalid_count + 1'b1;
                case (state)
                    S_END9:  outcome <= OUT_END9;
                    S_END10: outcome <= OUT_END10;
                    S_END13: outcome <= OUT_END13;
                    default: outcome <= outcome;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_player.sv
// Bench for game_player: drives the game-state code as a stand-in game FSM,
// models the script FIFO with a queue and checks results per playthrough.
module tb_game_player;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 32;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic [1:0] load_decision;
    logic       load_ready;
    logic       start;
    logic [4:0] state;
    logic       game_rst;
    logic [1:0] Decision;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] outcome;
    logic [7:0] move_count;
    logic [3:0] invalid_count;

    game_player #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_decision (load_decision),
        .load_ready    (load_ready),
        .start         (start),
        .state         (state),
        .game_rst      (game_rst),
        .Decision      (Decision),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .outcome       (outcome),
        .move_count    (move_count),
        .invalid_count (invalid_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: queue mirrors the DUT script FIFO contents.
    logic [1:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;
    bit         model_play = 1'b0;

    typedef struct {
        logic [0:3][1:0] script;
        int              n_script;
        logic [0:7][4:0] walk;
        int              n_walk;
        logic            exp_done;
        logic            exp_error;
        logic [1:0]      exp_outcome;
        logic [7:0]      exp_moves;
        logic [3:0]      exp_invalid;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [0:3][1:0] sc, input int ns,
                                input logic [0:7][4:0] wk, input int nw,
                                input logic d, input logic e, input logic [1:0] o,
                                input logic [7:0] m, input logic [3:0] iv);
        vec_t v;
        v.script = sc;  v.n_script = ns;
        v.walk = wk;    v.n_walk = nw;
        v.exp_done = d; v.exp_error = e; v.exp_outcome = o;
        v.exp_moves = m; v.exp_invalid = iv;
        return v;
    endfunction

    function automatic bit tb_is_dec(input logic [4:0] s);
        return (s == 5'd1) || (s == 5'd2) || (s == 5'd6) || (s == 5'd11) || (s == 5'd12);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks: inputs change at negedge, outputs sampled 1 time unit later.
    task automatic load_entry(input logic [1:0] v);
        bit exp_rdy;
        @(negedge clk);
        load_valid    = 1'b1;
        load_decision = v;
        #1;
        exp_rdy = !model_play && (exp_q.size() < DEPTH);
        chk("load_ready", 32'(load_ready), 32'(exp_rdy));
        if (exp_rdy) exp_q.push_back(v);
    endtask

    task automatic load_end();
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic do_start();
        int  rst_cycles;
        bit  reached;
        rst_cycles = 0;
        reached    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        state = 5'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (busy && !game_rst) begin
                reached = 1'b1;
                break;
            end
            if (game_rst) rst_cycles++;
            @(negedge clk);
        end
        chk("reach_play", 32'(reached), 32'd1);
        chk("game_rst_cycles", 32'(rst_cycles), 32'd2);
        model_play = 1'b1;
    endtask

    // One PLAY-phase cycle with game state s; ends at the following negedge.
    task automatic play_cycle(input logic [4:0] s);
        bit next_play;
        state = s;
        #1;
        next_play = model_play;
        chk("busy", 32'(busy), 32'(model_play));
        chk("ready_busy", 32'(load_ready), 32'(!model_play && (exp_q.size() < DEPTH)));
        if (model_play) begin
            if (s >= 5'd21) begin
                next_play = 1'b0;
            end else if (tb_is_dec(s)) begin
                if (exp_q.size() == 0) next_play = 1'b0;
                else chk("decision", 32'(Decision), 32'(exp_q.pop_front()));
            end else if (exp_q.size() > 0) begin
                chk("decision_head", 32'(Decision), 32'(exp_q[0]));
            end
        end else begin
            chk("decision_idle", 32'(Decision), 32'd0);
        end
        model_play = next_play;
        @(negedge clk);
    endtask

    task automatic start_empty();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("empty_start_error", 32'(error), 32'd1);
        chk("empty_start_busy", 32'(busy), 32'd0);
        chk("empty_start_game_rst", 32'(game_rst), 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_game_rst"}, 32'(game_rst), 32'd0);
        chk({tag, "_decision"}, 32'(Decision), 32'd0);
        chk({tag, "_outcome"}, 32'(outcome), 32'd0);
        chk({tag, "_moves"}, 32'(move_count), 32'd0);
        chk({tag, "_invalid"}, 32'(invalid_count), 32'd0);
        chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b0; load_valid = 1'b0; load_decision = 2'd0;
        start = 1'b0; state = 5'd0;

        vecs[0] = mk({2'd0, 2'd0, 2'd0, 2'd0}, 3, {5'd1, 5'd2, 5'd6, 5'd10, 5'd21, 5'd0, 5'd0, 5'd0}, 5,
                     1'b1, 1'b0, 2'd2, 8'd3, 4'd0);
        vecs[1] = mk({2'd1, 2'd0, 2'd0, 2'd0}, 1, {5'd1, 5'd3, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}, 3,
                     1'b0, 1'b1, 2'd0, 8'd1, 4'd0);
        vecs[2] = mk({2'd0, 2'd1, 2'd0, 2'd0}, 2, {5'd1, 5'd16, 5'd3, 5'd16, 5'd2, 5'd21, 5'd0, 5'd0}, 6,
                     1'b1, 1'b0, 2'd0, 8'd2, 4'd2);
        vecs[3] = mk({2'd3, 2'd2, 2'd0, 2'd0}, 2, {5'd1, 5'd9, 5'd2, 5'd13, 5'd21, 5'd0, 5'd0, 5'd0}, 5,
                     1'b1, 1'b0, 2'd3, 8'd2, 4'd0);
        vecs[4] = mk({2'd2, 2'd0, 2'd0, 2'd0}, 1, {5'd11, 5'd22, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}, 2,
                     1'b0, 1'b1, 2'd0, 8'd1, 4'd0);
        vecs[5] = mk({2'd1, 2'd2, 2'd3, 2'd0}, 3, {5'd12, 5'd9, 5'd6, 5'd10, 5'd11, 5'd21, 5'd0, 5'd0}, 6,
                     1'b1, 1'b0, 2'd2, 8'd3, 4'd0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Start with an empty script
        start_empty();

        // Table-driven playthroughs
        foreach (vecs[k]) begin
            for (int i = 0; i < vecs[k].n_script; i++) load_entry(vecs[k].script[i]);
            load_end();
            do_start();
            for (int i = 0; i < vecs[k].n_walk; i++) play_cycle(vecs[k].walk[i]);
            state = 5'd0;
            #1;
            chk($sformatf("v%0d_done", k), 32'(done), 32'(vecs[k].exp_done));
            chk($sformatf("v%0d_error", k), 32'(error), 32'(vecs[k].exp_error));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'd0);
            chk($sformatf("v%0d_outcome", k), 32'(outcome), 32'(vecs[k].exp_outcome));
            chk($sformatf("v%0d_moves", k), 32'(move_count), 32'(vecs[k].exp_moves));
            chk($sformatf("v%0d_invalid", k), 32'(invalid_count), 32'(vecs[k].exp_invalid));
        end

        // Fill the FIFO, refuse a 17th entry, then play all 16 with an ignored start
        for (int i = 0; i < DEPTH + 1; i++) load_entry(2'($urandom_range(0, 3)));
        load_end();
        #1;
        chk("full_ready", 32'(load_ready), 32'd0);
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            start = (i == 5);
            play_cycle(5'd1);
            start = 1'b0;
        end
        play_cycle(5'd21);
        state = 5'd0;
        #1;
        chk("full_done", 32'(done), 32'd1);
        chk("full_moves", 32'(move_count), 32'(DEPTH));
        chk("full_ready_after", 32'(load_ready), 32'd1);

        // Stall timeout: TIMEOUT transit cycles in PLAY
        load_entry(2'd1);
        load_end();
        do_start();
        for (int i = 0; i < TIMEOUT; i++) play_cycle(5'd4);
        model_play = 1'b0;
        state = 5'd0;
        #1;
        chk("timeout_error", 32'(error), 32'd1);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_moves", 32'(move_count), 32'd0);

        // Reset mid-PLAY with entries still queued
        load_entry(2'd2);
        load_end();
        do_start();
        play_cycle(5'd1);
        play_cycle(5'd9);
        reset = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        exp_q.delete();
        model_play = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_player.md
GAME_PLAYER -- requirements
Module: game_player

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning script FIFO entries (power of two).
REQ-002 SHALL have parameter TIMEOUT, default 32, meaning max cycles between decision states before a stall error.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load_valid, input, 1, a script entry is offered.
REQ-006 SHALL have port load_decision, input, 2, the script entry value (0-3).
REQ-007 SHALL have port load_ready, output, 1, FIFO can accept an entry.
REQ-008 SHALL have port start, input, 1, a one-cycle pulse that begins a playthrough.
REQ-009 SHALL have port state, input, 5, the game state code driven by the game FSM.
REQ-010 SHALL have port game_rst, output, 1, active-high synchronous reset driven to the game FSM.
REQ-011 SHALL have port Decision, output, 2, the decision presented to the game FSM.
REQ-012 SHALL have ports busy, done and error, each output, 1: playthrough running, finished, aborted.
REQ-013 SHALL have port outcome, output, 2: 0 = none, 1 = ending 9, 2 = ending 10, 3 = ending 13.
REQ-014 SHALL have ports move_count (output, 8, decisions consumed) and invalid_count (output, 4, entries into state 16).

Function
REQ-015 A load is accepted on any cycle with load_valid && load_ready; load_ready = !full && !busy.
REQ-016 Decision states SHALL be {1,2,6,11,12}; terminal state SHALL be 21; invalid state SHALL be 16; all other codes are transit states.
REQ-017 FSM states SHALL be IDLE, RST1, RST2, PLAY, FINISH, FAIL.
REQ-018 IDLE: start with FIFO non-empty -> RST1; start with FIFO empty -> FAIL, error=1 the next cycle.
REQ-019 RST1 -> RST2 -> PLAY; game_rst=1 in RST1 and RST2 only; move_count, invalid_count and outcome are cleared on entry to RST1.
REQ-020 In PLAY, Decision = FIFO head combinationally; in all other FSM states Decision = 0.
REQ-021 In PLAY, each cycle state is a decision state and the FIFO is non-empty, the head SHALL be popped at that edge and move_count incremented, saturating at 255.
REQ-022 In PLAY, a decision state with an empty FIFO -> FAIL (script exhausted).
REQ-023 In PLAY, each cycle state==16, invalid_count increments, saturating at 15.
REQ-024 In PLAY, state 9, 10 or 13 SHALL set outcome to 1, 2 or 3 respectively (last seen wins).
REQ-025 In PLAY, state==21 -> FINISH; done=1 and busy=0 in FINISH; remaining FIFO entries are retained.
REQ-026 A stall counter SHALL clear on each decision-state cycle and increment otherwise; reaching TIMEOUT -> FAIL.
REQ-027 A state code >21 in PLAY -> FAIL immediately.
REQ-028 busy=1 in RST1, RST2 and PLAY; error=1 only in FAIL.
REQ-029 FINISH or FAIL -> IDLE on start, which is then treated as in IDLE in the same cycle (FIFO-empty check applies).
REQ-030 start while busy SHALL be ignored; loads while busy SHALL be refused via load_ready=0.

Reset
REQ-031 Asserting reset SHALL asynchronously force IDLE, empty the FIFO and clear stall counter, move_count, invalid_count, outcome, done, error, busy, Decision and game_rst to 0; load_ready=1.
REQ-032 Reset asserted mid-playthrough SHALL abort with no partial outcome retained; deassertion takes effect at the next clock edge.

Structure
REQ-033 Shared package game_pkg SHALL hold the state-code constants (1,2,6,9,10,11,12,13,16,21), the outcome encoding and the player FSM enum.
REQ-034 The script FIFO SHALL be the sub-module decision_fifo (DEPTH x 2 bits, show-ahead head, full/empty flags).

Verification
REQ-035 Load [0,0,0], start, game model walks 1->2->6->10->21 -> done=1, outcome=2, move_count=3, invalid_count=0.
REQ-036 Load [1], start, game model walks 1->3->1 -> FAIL at the second state 1 (empty FIFO), error=1, move_count=1.
REQ-037 Load 16 entries -> load_ready=0 after the 16th; a 17th offer is not accepted; start -> game_rst high exactly 2 cycles.
REQ-038 Game model holds state=4 for 32 cycles in PLAY -> error=1 on timeout; start with FIFO empty -> error=1.
REQ-039 Game model enters 16 twice then reaches 21 -> invalid_count=2, done=1; reset asserted mid-PLAY -> all outputs 0 immediately.
